mem_arbiter: RTL and testbench

Two-port-to-one memory arbiter for the toothless core. It shares a single external memory bus between the instruction-fetch port (program counter side) and the load/store unit data port. Conflicts are resolved round-robin, with one outstanding transaction at a time. A response watchdog guarantees forward progress if memory never answers.

---
 rtl/toothless_pkg.sv | 26 ++
 rtl/mem_arbiter_rr.sv | 63 ++++++
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/toothless_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : toothless_pkg
//  Purpose  : Shared types and constants for the toothless memory arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package toothless_pkg;

    // Arbiter transaction phases
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        WAIT = 2'd2
    } arb_state_e;

    // Which port owns the outstanding transaction
    typedef enum logic {
        OWNER_INSTR = 1'b0,
        OWNER_DATA  = 1'b1
    } arb_owner_e;

    // Full-word byte enable used for instruction fetches
    localparam logic [3:0] BE_WORD = 4'b1111;

endpackage : toothless_pkg
`default_nettype wire

// File: rtl/mem_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter_2
//  Purpose  : Two-requester round-robin grant logic with last-owner history.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter_2
    import toothless_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic       req_instr_i,
    input  logic       req_data_i,
    output logic       gnt_instr_o,
    output logic       gnt_data_o,
    output arb_owner_e winner_o
);

    arb_owner_e last_owner_q;
    arb_owner_e last_owner_d;

    // Grant decision: a lone requester wins, on conflict the port not served last wins
    always_comb begin
        gnt_instr_o = 1'b0;
        gnt_data_o  = 1'b0;
        if (en_i) begin
            if (req_instr_i && req_data_i) begin
                if (last_owner_q == OWNER_INSTR) begin
                    gnt_data_o = 1'b1;
                end else begin
                    gnt_instr_o = 1'b1;
                end
            end else begin
                gnt_instr_o = req_instr_i;
                gnt_data_o  = req_data_i;
            end
        end
    end

    // History update only when a grant is actually issued
    always_comb begin
        last_owner_d = last_owner_q;
        if (gnt_data_o) begin
            last_owner_d = OWNER_DATA;
        end else if (gnt_instr_o) begin
            last_owner_d = OWNER_INSTR;
        end
    end

    assign winner_o = gnt_data_o ? OWNER_DATA : OWNER_INSTR;

    // Last-owner flop; resetting to INSTR makes the first conflict go to data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner_q <= OWNER_INSTR;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end

endmodule : rr_arbiter_2
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Shares one memory bus between fetch and LSU ports, one
//             outstanding transaction, with a response watchdog.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import toothless_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_req_i,
    input  logic [ADDR_WIDTH-1:0] instr_addr_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    output logic [DATA_WIDTH-1:0] instr_rdata_o,
    input  logic                  data_req_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    output logic [DATA_WIDTH-1:0] data_rdata_o,
    output logic                  err_o,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int                CNT_W  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  TO_VAL = CNT_W'(TIMEOUT);

    arb_state_e            state_q,  state_d;
    arb_owner_e            owner_q,  owner_d;
    logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
    logic                  we_q,     we_d;
    logic [3:0]            be_q,     be_d;
    logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;
    logic [CNT_W-1:0]      cnt_q,    cnt_d;

    logic                  w_arb_en;
    logic                  w_gnt_instr;
    logic                  w_gnt_data;
    arb_owner_e            w_winner;
    logic                  w_timeout;
    logic                  w_rsp_valid;

    // Grants only in IDLE and never while reset is held
    assign w_arb_en = (state_q == IDLE) && rst_n;

    rr_arbiter_2 u_rr (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (w_arb_en),
        .req_instr_i (instr_req_i),
        .req_data_i  (data_req_i),
        .gnt_instr_o (w_gnt_instr),
        .gnt_data_o  (w_gnt_data),
        .winner_o    (w_winner)
    );

    assign instr_gnt_o = w_gnt_instr;
    assign data_gnt_o  = w_gnt_data;

    // A real response takes priority over a watchdog expiry in the same cycle
    assign w_timeout   = (TIMEOUT != 0) && (state_q == WAIT) && !mem_rvalid_i && (cnt_q == TO_VAL);
    assign w_rsp_valid = (state_q == WAIT) && (mem_rvalid_i || w_timeout);

    assign err_o          = w_timeout;
    assign instr_rvalid_o = w_rsp_valid && (owner_q == OWNER_INSTR);
    assign data_rvalid_o  = w_rsp_valid && (owner_q == OWNER_DATA);
    assign instr_rdata_o  = (instr_rvalid_o && !w_timeout) ? mem_rdata_i : '0;
    assign data_rdata_o   = (data_rvalid_o  && !w_timeout) ? mem_rdata_i : '0;

    // Bus side is driven purely from flops so it cannot move during BUS
    assign mem_req_o   = (state_q == BUS);
    assign mem_addr_o  = addr_q;
    assign mem_we_o    = we_q;
    assign mem_be_o    = be_q;
    assign mem_wdata_o = wdata_q;

    // Next-state: capture on grant, wait for bus gnt, then response or watchdog
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (w_gnt_instr || w_gnt_data) begin
                    owner_d = w_winner;
                    state_d = BUS;
                    if (w_gnt_data) begin
                        addr_d  = data_addr_i;
                        we_d    = data_we_i;
                        be_d    = data_be_i;
                        wdata_d = data_wdata_i;
                    end else begin
                        addr_d  = instr_addr_i;
                        we_d    = 1'b0;
                        be_d    = BE_WORD;
                        wdata_d = '0;
                    end
                end
            end
            BUS: begin
                if (mem_gnt_i) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                if (w_rsp_valid) begin
                    state_d = IDLE;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and captured-request registers; reset drops any transaction at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= OWNER_INSTR;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= 4'b0000;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Directed self-checking bench for mem_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i;
    logic [31:0] data_addr_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        err_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    int total;
    int bad;

    mem_arbiter #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .TIMEOUT    (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .data_req_i     (data_req_i),
        .data_addr_i    (data_addr_i),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_wdata_i   (data_wdata_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .err_o          (err_o),
        .mem_req_o      (mem_req_o),
        .mem_addr_o     (mem_addr_o),
        .mem_we_o       (mem_we_o),
        .mem_be_o       (mem_be_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Every output against its reset value
    task automatic chk_reset(input string tag);
        chk({tag, "_igt"}, {31'd0, instr_gnt_o}, 32'd0);
        chk({tag, "_dgt"}, {31'd0, data_gnt_o}, 32'd0);
        chk({tag, "_irv"}, {31'd0, instr_rvalid_o}, 32'd0);
        chk({tag, "_drv"}, {31'd0, data_rvalid_o}, 32'd0);
        chk({tag, "_err"}, {31'd0, err_o}, 32'd0);
        chk({tag, "_mreq"}, {31'd0, mem_req_o}, 32'd0);
        chk({tag, "_mwe"}, {31'd0, mem_we_o}, 32'd0);
        chk({tag, "_maddr"}, mem_addr_o, 32'd0);
        chk({tag, "_mwd"}, mem_wdata_o, 32'd0);
        chk({tag, "_mbe"}, {28'd0, mem_be_o}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst_n        = 1'b0;
        instr_req_i  = 1'b0;
        instr_addr_i = 32'd0;
        data_req_i   = 1'b0;
        data_addr_i  = 32'd0;
        data_we_i    = 1'b0;
        data_be_i    = 4'd0;
        data_wdata_i = 32'd0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'd0;

        #3;
        chk_reset("rst");
        tick();
        tick();
        rst_n = 1'b1;

        // ---- instr-only read of 0x100 ----
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h100;
        settle();
        chk("t1_igt_c0", {31'd0, instr_gnt_o}, 32'd1);
        chk("t1_dgt_c0", {31'd0, data_gnt_o}, 32'd0);
        tick();
        instr_req_i = 1'b0;
        mem_gnt_i   = 1'b1;
        settle();
        chk("t1_mreq_c1", {31'd0, mem_req_o}, 32'd1);
        chk("t1_maddr_c1", mem_addr_o, 32'h100);
        chk("t1_mbe_c1", {28'd0, mem_be_o}, 32'hF);
        chk("t1_mwe_c1", {31'd0, mem_we_o}, 32'd0);
        chk("t1_irv_c1", {31'd0, instr_rvalid_o}, 32'd0);
        tick();
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hDEADBEEF;
        settle();
        chk("t1_irv_c2", {31'd0, instr_rvalid_o}, 32'd1);
        chk("t1_ird_c2", instr_rdata_o, 32'hDEADBEEF);
        chk("t1_drv_c2", {31'd0, data_rvalid_o}, 32'd0);
        chk("t1_err_c2", {31'd0, err_o}, 32'd0);
        chk("t1_mreq_c2", {31'd0, mem_req_o}, 32'd0);
        tick();
        mem_rvalid_i = 1'b0;
        settle();
        chk("t1_irv_c3", {31'd0, instr_rvalid_o}, 32'd0);
        chk("t1_drv_c3", {31'd0, data_rvalid_o}, 32'd0);

        // ---- fresh reset, then conflict: data write wins first ----
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h104;
        data_req_i   = 1'b1;
        data_addr_i  = 32'h200;
        data_we_i    = 1'b1;
        data_be_i    = 4'b0011;
        data_wdata_i = 32'h12345678;
        settle();
        chk("t2_dgt_c0", {31'd0, data_gnt_o}, 32'd1);
        chk("t2_igt_c0", {31'd0, instr_gnt_o}, 32'd0);
        tick();
        data_req_i = 1'b0;
        mem_gnt_i  = 1'b1;
        settle();
        chk("t2_mwe", {31'd0, mem_we_o}, 32'd1);
        chk("t2_maddr", mem_addr_o, 32'h200);
        chk("t2_mwd", mem_wdata_o, 32'h12345678);
        chk("t2_mbe", {28'd0, mem_be_o}, 32'h3);
        chk("t2_igt_bus", {31'd0, instr_gnt_o}, 32'd0);
        tick();
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h0;
        settle();
        chk("t2_drv", {31'd0, data_rvalid_o}, 32'd1);
        chk("t2_irv", {31'd0, instr_rvalid_o}, 32'd0);
        chk("t2_igt_wait", {31'd0, instr_gnt_o}, 32'd0);
        tick();
        mem_rvalid_i = 1'b0;
        settle();
        chk("t2_igt_idle", {31'd0, instr_gnt_o}, 32'd1);
        chk("t2_dgt_idle", {31'd0, data_gnt_o}, 32'd0);
        tick();
        instr_req_i = 1'b0;
        mem_gnt_i   = 1'b1;
        settle();
        chk("t2_maddr_i", mem_addr_o, 32'h104);
        chk("t2_mwe_i", {31'd0, mem_we_o}, 32'd0);
        chk("t2_mbe_i", {28'd0, mem_be_o}, 32'hF);
        tick();
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hCAFEF00D;
        settle();
        chk("t2_irv_2", {31'd0, instr_rvalid_o}, 32'd1);
        chk("t2_ird_2", instr_rdata_o, 32'hCAFEF00D);
        tick();
        mem_rvalid_i = 1'b0;

        // ---- second conflict: data wins again; then bus stalls gnt 4 cycles ----
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h108;
        data_req_i   = 1'b1;
        data_addr_i  = 32'h300;
        data_we_i    = 1'b0;
        data_be_i    = 4'b1111;
        settle();
        chk("t3_dgt", {31'd0, data_gnt_o}, 32'd1);
        chk("t3_igt", {31'd0, instr_gnt_o}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            data_req_i   = k[0];
            data_addr_i  = 32'h400 + k;
            instr_addr_i = 32'h500 + k;
            data_we_i    = ~k[0];
            mem_gnt_i    = (k == 3);
            settle();
            chk($sformatf("t3_mreq_%0d", k), {31'd0, mem_req_o}, 32'd1);
            chk($sformatf("t3_maddr_%0d", k), mem_addr_o, 32'h300);
            chk($sformatf("t3_mwe_%0d", k), {31'd0, mem_we_o}, 32'd0);
            chk($sformatf("t3_gnts_%0d", k), {30'd0, instr_gnt_o, data_gnt_o}, 32'd0);
        end
        tick();
        mem_gnt_i    = 1'b0;
        instr_req_i  = 1'b0;
        data_req_i   = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h0BADF00D;
        settle();
        chk("t3_mreq_wait", {31'd0, mem_req_o}, 32'd0);
        chk("t3_drv", {31'd0, data_rvalid_o}, 32'd1);
        chk("t3_drd", data_rdata_o, 32'h0BADF00D);
        tick();
        mem_rvalid_i = 1'b0;

        // ---- watchdog: memory never answers ----
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h600;
        settle();
        chk("t4_igt", {31'd0, instr_gnt_o}, 32'd1);
        tick();
        instr_req_i = 1'b0;
        mem_gnt_i   = 1'b1;
        mem_rdata_i = 32'hFFFFFFFF;
        tick();
        mem_gnt_i = 1'b0;
        // now in the first WAIT cycle
        for (int k = 0; k < 16; k++) begin
            settle();
            chk($sformatf("t4_quiet_%0d", k), {30'd0, instr_rvalid_o, err_o}, 32'd0);
            tick();
        end
        settle();
        chk("t4_irv_to", {31'd0, instr_rvalid_o}, 32'd1);
        chk("t4_err_to", {31'd0, err_o}, 32'd1);
        chk("t4_ird_to", instr_rdata_o, 32'd0);
        chk("t4_drv_to", {31'd0, data_rvalid_o}, 32'd0);
        tick();
        mem_rvalid_i = 1'b1;
        settle();
        chk("t4_stray_irv", {31'd0, instr_rvalid_o}, 32'd0);
        chk("t4_stray_drv", {31'd0, data_rvalid_o}, 32'd0);
        chk("t4_stray_err", {31'd0, err_o}, 32'd0);
        tick();
        mem_rvalid_i = 1'b0;

        // ---- reset asserted while in WAIT ----
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h700;
        tick();
        instr_req_i = 1'b0;
        mem_gnt_i   = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        settle();
        chk("t5_inwait_mreq", {31'd0, mem_req_o}, 32'd0);
        chk("t5_inwait_maddr", mem_addr_o, 32'h700);
        rst_n        = 1'b0;
        mem_rvalid_i = 1'b1;
        settle();
        chk_reset("t5_rst");
        tick();
        settle();
        chk("t5_rst_irv", {31'd0, instr_rvalid_o}, 32'd0);
        tick();
        mem_rvalid_i = 1'b0;
        rst_n        = 1'b1;
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h800;
        settle();
        chk("t5_igt_after", {31'd0, instr_gnt_o}, 32'd1);
        tick();
        instr_req_i = 1'b0;
        settle();
        chk("t5_maddr_after", mem_addr_o, 32'h800);
        chk("t5_mreq_after", {31'd0, mem_req_o}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire
